// File: rtl/bcd_seg_scan_pkg.sv
// Shared definitions for the BCD score display scanner: segment codes,
// slot encodings and scan FSM state encodings.
package bcd_seg_scan_pkg;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  // Digit slot encodings; slot index also selects the anode bit
  localparam logic [1:0] SLOT_ONES     = 2'd0;
  localparam logic [1:0] SLOT_TENS     = 2'd1;
  localparam logic [1:0] SLOT_HUNDREDS = 2'd2;

  // Scan FSM state encodings
  localparam logic [0:0] ST_SHOW  = 1'b0;
  localparam logic [0:0] ST_GUARD = 1'b1;

  localparam logic [3:0] AN_OFF = 4'hF;

endpackage

// File: rtl/bcd_seg_scan_bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg
  import bcd_seg_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for one digit
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Three-digit multiplexed driver for a common-anode 7-segment display with
// frame-synchronous digit capture, leading-zero blanking and a dark guard
// interval between digit slots.
module bcd_seg_scan
  import bcd_seg_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17,
  parameter int GUARD_CYC   = 4,
  parameter int LZ_BLANK    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [GW-1:0]    GC_LAST = GW'(GUARD_CYC - 1);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [1:0]       slot;
  logic [0:0]       state;
  logic [GW-1:0]    guard_cnt;
  logic [3:0]       sh_h, sh_t, sh_o;
  logic [3:0]       cur_digit;
  logic [6:0]       cur_seg;
  logic [3:0]       cur_an;
  logic             cur_blank;

  assign dp   = 1'b1;
  assign tick = (cnt == CNT_MAX);

  // Slot-rate prescaler
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  // Slot rotation; digits are latched only when a new frame starts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot <= SLOT_HUNDREDS;
      sh_h <= '0;
      sh_t <= '0;
      sh_o <= '0;
    end else if (tick) begin
      if (slot == SLOT_HUNDREDS || slot == 2'd3) begin
        slot <= SLOT_ONES;
        sh_h <= hundreds;
        sh_t <= tens;
        sh_o <= ones;
      end else begin
        slot <= slot + 2'd1;
      end
    end
  end

  // Select the captured digit, its anode and its leading-zero status
  always_comb begin
    cur_digit = sh_h;
    cur_an    = AN_OFF;
    cur_blank = 1'b0;
    case (slot)
      SLOT_ONES: begin
        cur_digit = sh_o;
        cur_an    = 4'b1110;
      end
      SLOT_TENS: begin
        cur_digit = sh_t;
        cur_an    = 4'b1101;
        cur_blank = (LZ_BLANK != 0) && (sh_h == 4'd0) && (sh_t == 4'd0);
      end
      SLOT_HUNDREDS: begin
        cur_digit = sh_h;
        cur_an    = 4'b1011;
        cur_blank = (LZ_BLANK != 0) && (sh_h == 4'd0);
      end
      default: begin
        cur_digit = sh_h;
        cur_an    = AN_OFF;
        cur_blank = 1'b1;
      end
    endcase
  end

  bcd_to_seg u_dec (
    .bcd (cur_digit),
    .seg (cur_seg)
  );

  // Scan FSM: dark guard after each slot change, then light the new slot.
  // The blank override sits last so it wins over any FSM output update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_GUARD;
      guard_cnt <= '0;
      an        <= AN_OFF;
      seg       <= SEG_OFF;
    end else begin
      case (state)
        ST_SHOW: begin
          if (tick) begin
            state     <= ST_GUARD;
            guard_cnt <= '0;
            an        <= AN_OFF;
            seg       <= SEG_OFF;
          end
        end
        default: begin
          if (tick) begin
            guard_cnt <= '0;
            an        <= AN_OFF;
            seg       <= SEG_OFF;
          end else if (guard_cnt == GC_LAST) begin
            state <= ST_SHOW;
            if (cur_blank) begin
              an  <= AN_OFF;
              seg <= SEG_OFF;
            end else begin
              an  <= cur_an;
              seg <= cur_seg;
            end
          end else begin
            guard_cnt <= guard_cnt + 1'b1;
          end
        end
      endcase
      if (blank) begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Scoreboard bench for bcd_seg_scan (REFRESH_DIV=8, GUARD_CYC=2).
// Cycle n = outputs after the n-th clock edge following reset release (n=0 first).
module tb_bcd_seg_scan;
  import bcd_seg_scan_pkg::*;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    string      nm;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] hundreds = '0, tens = '0, ones = '0;
  logic       blank = 1'b0;
  logic [6:0] seg1, seg2;
  logic [3:0] an1, an2;
  logic       dp1, dp2;

  int   cyc = -1;
  int   tests = 0;
  int   fails = 0;
  int   an3_bad = 0;
  int   guard_tick_bad = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e;

  bcd_seg_scan #(.REFRESH_DIV(8), .CNT_W(3), .GUARD_CYC(2), .LZ_BLANK(1)) dut1 (
    .clk(clk), .reset(reset), .hundreds(hundreds), .tens(tens), .ones(ones),
    .blank(blank), .seg(seg1), .dp(dp1), .an(an1)
  );

  bcd_seg_scan #(.REFRESH_DIV(8), .CNT_W(3), .GUARD_CYC(2), .LZ_BLANK(0)) dut2 (
    .clk(clk), .reset(reset), .hundreds(hundreds), .tens(tens), .ones(ones),
    .blank(blank), .seg(seg2), .dp(dp2), .an(an2)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= -1;
    else       cyc <= cyc + 1;
  end

  // Monitor: compares DUT outputs against queued expectations for this cycle
  always @(negedge clk) begin
    if (q1.size() > 0 && q1[0].cyc == cyc) begin
      e = q1.pop_front();
      tests++;
      if (an1 !== e.an || seg1 !== e.seg) begin
        fails++;
        $display("FAIL %s cyc=%0d: got an=%h seg=%h, expected an=%h seg=%h",
                 e.nm, cyc, an1, seg1, e.an, e.seg);
      end
    end
    if (q2.size() > 0 && q2[0].cyc == cyc) begin
      e = q2.pop_front();
      tests++;
      if (an2 !== e.an || seg2 !== e.seg) begin
        fails++;
        $display("FAIL %s cyc=%0d: got an=%h seg=%h, expected an=%h seg=%h",
                 e.nm, cyc, an2, seg2, e.an, e.seg);
      end
    end
    if (!reset) begin
      if (an1[3] !== 1'b1 || an2[3] !== 1'b1 || dp1 !== 1'b1 || dp2 !== 1'b1)
        an3_bad++;
      if (dut1.state == ST_GUARD && dut1.tick) guard_tick_bad++;
    end
  end

  task automatic exp1(input int c, input logic [3:0] a, input logic [6:0] s, input string nm);
    exp_t x;
    x.cyc = c; x.an = a; x.seg = s; x.nm = nm;
    q1.push_back(x);
  endtask

  task automatic exp2(input int c, input logic [3:0] a, input logic [6:0] s, input string nm);
    exp_t x;
    x.cyc = c; x.an = a; x.seg = s; x.nm = nm;
    q2.push_back(x);
  endtask

  // Reset both DUTs with the given digits, release two edges later
  task automatic start(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    @(posedge clk); #2;
    reset = 1'b1;
    blank = 1'b0;
    hundreds = h; tens = t; ones = o;
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    int t = 0;
    while (cyc != n && t < 500) begin
      @(posedge clk); #2;
      t++;
    end
    if (cyc != n) begin
      tests++;
      fails++;
      $display("FAIL wait_cyc: got cyc=%0d, expected %0d", cyc, n);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((q1.size() > 0 || q2.size() > 0) && t < 200) begin
      @(posedge clk);
      t++;
    end
    while (q1.size() > 0) begin
      e = q1.pop_front();
      tests++; fails++;
      $display("FAIL %s timeout: got no check at cyc=%0d, expected an=%h seg=%h", e.nm, e.cyc, e.an, e.seg);
    end
    while (q2.size() > 0) begin
      e = q2.pop_front();
      tests++; fails++;
      $display("FAIL %s timeout: got no check at cyc=%0d, expected an=%h seg=%h", e.nm, e.cyc, e.an, e.seg);
    end
  endtask

  initial begin
    // Digits 1/2/3: basic scan order and timing
    exp1(-1, 4'hF, 7'h7F, "a_rst");
    exp1(0,  4'hF, 7'h7F, "a_dark0");
    exp1(4,  4'hF, 7'h7F, "a_dark4");
    exp1(8,  4'hF, 7'h7F, "a_dark8");
    exp1(9,  4'hE, 7'h30, "a_ones");
    exp1(15, 4'hF, 7'h7F, "a_guard15");
    exp1(17, 4'hD, 7'h24, "a_tens");
    exp1(23, 4'hF, 7'h7F, "a_guard23");
    exp1(25, 4'hB, 7'h79, "a_hund");
    exp1(33, 4'hE, 7'h30, "a_ones2");
    exp1(41, 4'hD, 7'h24, "a_tens2");
    exp1(49, 4'hB, 7'h79, "a_hund2");
    start(4'd1, 4'd2, 4'd3);
    drain();

    // Digits 0/0/7: leading zeros blanked
    exp1(9,  4'hE, 7'h78, "b_ones");
    exp1(17, 4'hF, 7'h7F, "b_tens_blank");
    exp1(20, 4'hF, 7'h7F, "b_tens_blank2");
    exp1(25, 4'hF, 7'h7F, "b_hund_blank");
    exp1(33, 4'hE, 7'h78, "b_ones2");
    start(4'd0, 4'd0, 4'd7);
    drain();

    // Digits 0/0/0: ones only with blanking, all zeros without
    exp1(9,  4'hE, 7'h40, "c_ones");
    exp1(17, 4'hF, 7'h7F, "c_tens_blank");
    exp1(25, 4'hF, 7'h7F, "c_hund_blank");
    exp2(9,  4'hE, 7'h40, "c_nolz_ones");
    exp2(17, 4'hD, 7'h40, "c_nolz_tens");
    exp2(25, 4'hB, 7'h40, "c_nolz_hund");
    start(4'd0, 4'd0, 4'd0);
    drain();

    // 4/5/6 changed to 9/9/9 while tens slot is lit: frame stays intact
    exp1(9,  4'hE, 7'h02, "d_ones6");
    exp1(17, 4'hD, 7'h12, "d_tens5");
    exp1(25, 4'hB, 7'h19, "d_hund4");
    exp1(30, 4'hB, 7'h19, "d_hund4_hold");
    exp1(33, 4'hE, 7'h10, "d_ones9");
    exp1(41, 4'hD, 7'h10, "d_tens9");
    exp1(49, 4'hB, 7'h10, "d_hund9");
    start(4'd4, 4'd5, 4'd6);
    wait_cyc(20);
    hundreds = 4'd9; tens = 4'd9; ones = 4'd9;
    drain();

    // Invalid tens with zero hundreds: hundreds blank, tens dash
    exp1(9,  4'hE, 7'h30, "e_ones");
    exp1(17, 4'hD, 7'h3F, "e_tens_dash");
    exp1(25, 4'hF, 7'h7F, "e_hund_blank");
    start(4'd0, 4'hC, 4'd3);
    drain();

    // Invalid hundreds counts as non-zero: zero tens still shown
    exp1(9,  4'hE, 7'h12, "e2_ones");
    exp1(17, 4'hD, 7'h40, "e2_tens0");
    exp1(25, 4'hB, 7'h3F, "e2_hund_dash");
    start(4'hA, 4'd0, 4'd5);
    drain();

    // Blank window, then async reset in the guard interval
    exp1(9,  4'hF, 7'h7F, "f_blank9");
    exp1(17, 4'hF, 7'h7F, "f_blank17");
    exp1(25, 4'hF, 7'h7F, "f_blank25");
    exp1(33, 4'hF, 7'h7F, "f_blank33");
    exp1(41, 4'hD, 7'h24, "f_unblank_tens");
    exp1(46, 4'hD, 7'h24, "f_tens_hold");
    exp1(-1, 4'hF, 7'h7F, "f_async_rst");
    exp1(8,  4'hF, 7'h7F, "f_restart_dark");
    exp1(9,  4'hE, 7'h30, "f_restart_ones");
    start(4'd1, 4'd2, 4'd3);
    wait_cyc(5);
    blank = 1'b1;
    wait_cyc(35);
    blank = 1'b0;
    wait_cyc(47);
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    drain();

    tests++;
    if (an3_bad != 0) begin
      fails++;
      $display("FAIL an3_dp_high: got %0d bad cycles, expected 0", an3_bad);
    end
    tests++;
    if (guard_tick_bad != 0) begin
      fails++;
      $display("FAIL tick_in_guard: got %0d occurrences, expected 0", guard_tick_bad);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
